// File: rtl/fm_phaseinc_gen_pkg.sv
// Shared widths and interpolator state encoding for the FM modulator datapath.
// The DDS stage imports the same package so both sides agree on widths.
package fm_phaseinc_gen_pkg;

  localparam int NBITS_AUDIO     = 16;
  localparam int NBITS_PHASE     = 32;
  localparam int NBITS_GAIN      = 16;
  localparam int GAIN_SHIFT      = 15;
  localparam int INTERP_LOG2_DEF = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } interp_state_e;

endpackage

// File: rtl/fm_interp_core.sv
// Linear interpolator: steps acc from the previous target to the new one over
// 2^INTERP_LOG2 enableclk ticks, snapping to the exact target at each load.
module fm_interp_core
  import fm_phaseinc_gen_pkg::*;
#(
  parameter int AUDIO_W     = 16,
  parameter int INTERP_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enableclk,
  input  logic                      hold_full,
  input  logic [AUDIO_W-1:0]        hold_data,
  output logic                      consume,
  output logic                      underrun_evt,
  output logic signed [AUDIO_W:0]   interp
);

  localparam int                     ACC_W    = AUDIO_W + INTERP_LOG2 + 1;
  localparam logic [INTERP_LOG2-1:0] CNT_LAST = '1;

  interp_state_e               state_q, state_d;
  logic signed [AUDIO_W-1:0]   tgt_q, tgt_d;
  logic signed [AUDIO_W:0]     diff_q, diff_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [INTERP_LOG2-1:0]      cnt_q, cnt_d;

  logic signed [AUDIO_W-1:0]   hold_s;
  logic signed [ACC_W-1:0]     tgt_scaled;
  logic                        boundary;
  logic                        load;

  assign hold_s     = hold_data;
  assign tgt_scaled = ACC_W'(tgt_q) <<< INTERP_LOG2;
  assign boundary   = (cnt_q == CNT_LAST);
  assign load       = enableclk && hold_full && ((state_q == IDLE) || boundary);
  assign interp     = (AUDIO_W+1)'(acc_q >>> INTERP_LOG2);

  // Next-state: load, interpolation step, or flat hold on an empty boundary.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    tgt_d        = tgt_q;
    diff_d       = diff_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    consume      = 1'b0;
    underrun_evt = 1'b0;

    if (load) begin
      diff_d  = (AUDIO_W+1)'(hold_s) - (AUDIO_W+1)'(tgt_q);
      tgt_d   = hold_s;
      acc_d   = tgt_scaled;
      cnt_d   = '0;
      consume = 1'b1;
      state_d = RUN;
    end else if (enableclk && (state_q == RUN)) begin
      if (!boundary) begin
        acc_d = acc_q + ACC_W'(diff_q);
        cnt_d = cnt_q + INTERP_LOG2'(1);
      end else begin
        diff_d       = '0;
        acc_d        = tgt_scaled;
        cnt_d        = '0;
        underrun_evt = 1'b1;
      end
    end
  end

  // Interpolator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      diff_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      diff_q  <= diff_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/fm_phaseinc_gen.sv
// FM phase-increment generator: audio holding register and handshake,
// interpolator, deviation-gain pipeline and sticky underrun flag.
module fm_phaseinc_gen #(
  parameter int NBITS_AUDIO = fm_phaseinc_gen_pkg::NBITS_AUDIO,
  parameter int NBITS_PHASE = fm_phaseinc_gen_pkg::NBITS_PHASE,
  parameter int INTERP_LOG2 = fm_phaseinc_gen_pkg::INTERP_LOG2_DEF,
  parameter int NBITS_GAIN  = fm_phaseinc_gen_pkg::NBITS_GAIN,
  parameter int GAIN_SHIFT  = fm_phaseinc_gen_pkg::GAIN_SHIFT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enableclk,
  input  logic [NBITS_AUDIO-1:0] audio_in,
  input  logic                   audio_valid,
  output logic                   audio_ready,
  input  logic [NBITS_PHASE-1:0] carrier_inc,
  input  logic [NBITS_GAIN-1:0]  dev_gain,
  output logic [NBITS_PHASE-1:0] phaseinc,
  output logic                   underrun,
  input  logic                   clear_status
);

  localparam int PROD_W = NBITS_AUDIO + 1 + NBITS_GAIN + 1;

  logic                          hold_full_q, hold_full_d;
  logic [NBITS_AUDIO-1:0]        hold_q, hold_d;
  logic                          underrun_q, underrun_d;
  logic signed [PROD_W-1:0]      prod_q, prod_d;
  logic [NBITS_PHASE-1:0]        phaseinc_q, phaseinc_d;

  logic                          accept;
  logic                          consume;
  logic                          underrun_evt;
  logic signed [NBITS_AUDIO:0]   interp;
  logic signed [NBITS_GAIN:0]    gain_s;
  logic signed [PROD_W-1:0]      prod_sh;
  logic signed [NBITS_PHASE-1:0] dev_term;

  // Ready depends only on the registered fill flag, never on audio_valid.
  assign audio_ready = !hold_full_q;
  assign accept      = audio_valid && !hold_full_q;

  fm_interp_core #(
    .AUDIO_W     (NBITS_AUDIO),
    .INTERP_LOG2 (INTERP_LOG2)
  ) u_core (
    .clk          (clock),
    .rst_n        (reset),
    .enableclk    (enableclk),
    .hold_full    (hold_full_q),
    .hold_data    (hold_q),
    .consume      (consume),
    .underrun_evt (underrun_evt),
    .interp       (interp)
  );

  // Holding register: a load reads the old contents while an accept refills it.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q && !consume;
    if (accept) begin
      hold_d      = audio_in;
      hold_full_d = 1'b1;
    end
  end

  // Sticky underrun flag; a simultaneous event overrides the clear.
  always_comb begin
    underrun_d = underrun_q;
    if (clear_status) underrun_d = 1'b0;
    if (underrun_evt) underrun_d = 1'b1;
  end

  // Gain pipeline: signed x unsigned multiply, then shift and add carrier (wraps).
  always_comb begin
    gain_s     = {1'b0, dev_gain};
    prod_d     = PROD_W'(interp) * PROD_W'(gain_s);
    prod_sh    = prod_q >>> GAIN_SHIFT;
    dev_term   = NBITS_PHASE'(prod_sh);
    phaseinc_d = carrier_inc + dev_term;
  end

  // Top-level registers, including the holding register, all cleared on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      underrun_q  <= 1'b0;
      prod_q      <= '0;
      phaseinc_q  <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      underrun_q  <= underrun_d;
      prod_q      <= prod_d;
      phaseinc_q  <= phaseinc_d;
    end
  end

  assign phaseinc = phaseinc_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_fm_phaseinc_gen.sv
// Bench for fm_phaseinc_gen with INTERP_LOG2=2 and enableclk every 4 clocks.
// Expected phaseinc values are queued as samples are planned and popped per tick.
module tb_fm_phaseinc_gen;

  localparam int NA = 16;
  localparam int NP = 32;
  localparam int IL = 2;
  localparam int NG = 16;
  localparam int GS = 15;
  localparam int TPS = 1 << IL;

  logic          clock;
  logic          reset;
  logic          enableclk;
  logic [NA-1:0] audio_in;
  logic          audio_valid;
  logic          audio_ready;
  logic [NP-1:0] carrier_inc;
  logic [NG-1:0] dev_gain;
  logic [NP-1:0] phaseinc;
  logic          underrun;
  logic          clear_status;

  int checks;
  int errors;

  logic [NP-1:0]        exp_q[$];
  logic signed [NA-1:0] src_q[$];
  int                   plan[$];
  int                   acc_ticks[$];
  bit                   acc_pend;
  int                   pend_tick;
  int                   tick_cnt;
  int                   cur_gain;

  fm_phaseinc_gen #(
    .NBITS_AUDIO (NA),
    .NBITS_PHASE (NP),
    .INTERP_LOG2 (IL),
    .NBITS_GAIN  (NG),
    .GAIN_SHIFT  (GS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enableclk    (enableclk),
    .audio_in     (audio_in),
    .audio_valid  (audio_valid),
    .audio_ready  (audio_ready),
    .carrier_inc  (carrier_inc),
    .dev_gain     (dev_gain),
    .phaseinc     (phaseinc),
    .underrun     (underrun),
    .clear_status (clear_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: value interpolated k ticks from a toward b, gained, plus carrier.
  function automatic logic [NP-1:0] model_pi(input int a, input int b, input int k);
    int          acc;
    int          iv;
    longint      p;
    logic [NP-1:0] dev;
    acc = TPS * a + k * (b - a);
    iv  = acc >>> IL;
    p   = longint'(iv) * longint'(cur_gain);
    p   = p >>> GS;
    dev = p[NP-1:0];
    return carrier_inc + dev;
  endfunction

  // Queue plan[] as source samples and push expected phaseinc for n ticks.
  task automatic load_plan(input int n);
    int i;
    int k;
    int last;
    foreach (plan[j]) src_q.push_back(NA'(plan[j]));
    for (int t = 0; t < n; t++) begin
      i = t / TPS;
      k = t % TPS;
      if (plan.size() == 0) begin
        exp_q.push_back(model_pi(0, 0, 0));
      end else if (i < plan.size()) begin
        exp_q.push_back(model_pi((i == 0) ? 0 : plan[i-1], plan[i], k));
      end else begin
        last = plan[plan.size()-1];
        exp_q.push_back(model_pi(last, last, 0));
      end
    end
  endtask

  // One clock: retire last accept, present next sample, drive strobes.
  task automatic step(input bit en, input bit clr);
    @(negedge clock);
    if (acc_pend) begin
      acc_ticks.push_back(pend_tick);
      audio_valid = 1'b0;
    end
    if (!audio_valid && src_q.size() > 0) begin
      audio_in    = src_q.pop_front();
      audio_valid = 1'b1;
    end
    enableclk    = en;
    clear_status = clr;
    if (en) tick_cnt++;
    acc_pend  = audio_valid && audio_ready;
    pend_tick = tick_cnt;
  endtask

  // n enableclk ticks, 4 clocks each; phaseinc compared 3 clocks after the strobe.
  task automatic run_ticks(input int n, input bit clr, input string tag);
    logic [NP-1:0] e;
    for (int t = 0; t < n; t++) begin
      step(1'b1, clr);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty at tick %0d, phaseinc %h", tag, tick_cnt, phaseinc);
      end else begin
        e = exp_q.pop_front();
        if (phaseinc !== e) begin
          errors++;
          $display("FAIL %s tick %0d: phaseinc got %h expected %h", tag, tick_cnt, phaseinc, e);
        end
      end
    end
  endtask

  task automatic clear_bench();
    src_q.delete();
    exp_q.delete();
    plan.delete();
    acc_ticks.delete();
    audio_valid  = 1'b0;
    audio_in     = '0;
    enableclk    = 1'b0;
    clear_status = 1'b0;
    acc_pend     = 1'b0;
    tick_cnt     = 0;
  endtask

  task automatic do_reset(input logic [NP-1:0] car, input int gain);
    @(negedge clock);
    reset = 1'b0;
    clear_bench();
    carrier_inc = car;
    dev_gain    = NG'(gain);
    cur_gain    = gain;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic expect_val(input logic [NP-1:0] got, input logic [NP-1:0] exp, input string tag);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_bench();
    carrier_inc = 32'h1000_0000;
    dev_gain    = 16'h8000;
    cur_gain    = 32'h8000;
    repeat (3) @(negedge clock);
    expect_val(phaseinc, '0, "reset_phaseinc");
    expect_val(NP'(audio_ready), NP'(1), "reset_ready");
    expect_val(NP'(underrun), NP'(0), "reset_underrun");
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    expect_val(phaseinc, 32'h1000_0000, "post_reset_phaseinc");
    expect_val(NP'(audio_ready), NP'(1), "post_reset_ready");
  endtask

  task automatic test_ramp();
    do_reset(32'h1000_0000, 32'h8000);
    plan = '{0, 400};
    load_plan(12);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_ticks(12, 1'b0, "ramp");
    expect_val(phaseinc, 32'h1000_0190, "ramp_final");
  endtask

  task automatic test_neg_gain();
    do_reset(32'h1000_0000, 32'h4000);
    plan = '{0, -400};
    load_plan(12);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_ticks(12, 1'b0, "neg_gain");
    expect_val(phaseinc, 32'h0FFF_FF38, "neg_gain_final");
  endtask

  task automatic test_underrun();
    do_reset(32'h1000_0000, 32'h8000);
    plan = '{0, 400};
    load_plan(12);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_ticks(8, 1'b0, "underrun_pre");
    expect_val(NP'(underrun), NP'(0), "underrun_before_boundary");
    run_ticks(1, 1'b0, "underrun_boundary");
    expect_val(NP'(underrun), NP'(1), "underrun_set");
    expect_val(phaseinc, 32'h1000_0190, "underrun_hold");
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    expect_val(NP'(underrun), NP'(0), "underrun_cleared");
    run_ticks(3, 1'b0, "underrun_flat");
    expect_val(NP'(underrun), NP'(0), "underrun_stays_clear");
    exp_q.push_back(model_pi(400, 400, 0));
    run_ticks(1, 1'b1, "underrun_set_wins");
    expect_val(NP'(underrun), NP'(1), "underrun_set_wins_flag");
  endtask

  task automatic test_back_to_back();
    do_reset(32'h1000_0000, 32'h8000);
    for (int i = 0; i < 6; i++) plan.push_back(int'($urandom_range(16000)) - 8000);
    load_plan(6 * TPS + TPS);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_ticks(6 * TPS + TPS, 1'b0, "back_to_back");
    expect_val(NP'(acc_ticks.size()), NP'(6), "b2b_accept_count");
    for (int i = 2; i < acc_ticks.size(); i++)
      expect_val(NP'(acc_ticks[i] - acc_ticks[i-1]), NP'(TPS), $sformatf("b2b_accept_gap%0d", i));
  endtask

  task automatic test_wrap();
    do_reset(32'hFFFF_FF00, 32'h8000);
    plan = '{512};
    load_plan(8);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_ticks(8, 1'b0, "wrap");
    expect_val(phaseinc, 32'h0000_0100, "wrap_final");
  endtask

  task automatic test_midreset();
    do_reset(32'h1000_0000, 32'h8000);
    plan = '{0, 1000};
    load_plan(6);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_ticks(6, 1'b0, "midreset_pre");
    @(negedge clock);
    #2;
    reset = 1'b0;
    clear_bench();
    #1;
    expect_val(phaseinc, '0, "midreset_phaseinc");
    expect_val(NP'(audio_ready), NP'(1), "midreset_ready");
    @(negedge clock);
    reset = 1'b1;
    load_plan(4);
    step(1'b0, 1'b0);
    run_ticks(4, 1'b0, "midreset_idle");
    expect_val(NP'(underrun), NP'(0), "midreset_no_underrun");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ramp();
    test_neg_gain();
    test_underrun();
    test_back_to_back();
    test_wrap();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_phaseinc_gen.md
Name: fm_phaseinc_gen

Overview:
- Upstream neighbour of the DDS sine stage in the all-digital FM modulator.
- Accepts signed audio samples over a valid/ready handshake and linearly interpolates between consecutive samples across 2^INTERP_LOG2 enableclk ticks.
- Scales the interpolated value by a runtime deviation gain, adds the carrier phase increment, and drives the 32-bit phaseinc consumed by the DDS accumulator.

Parameters:
- NBITS_AUDIO, 16, audio sample width (signed two's complement).
- NBITS_PHASE, 32, phase increment width.
- INTERP_LOG2, 6, log2 of enableclk ticks per audio sample.
- NBITS_GAIN, 16, deviation gain width (unsigned).
- GAIN_SHIFT, 15, right shift after multiply; dev_gain = 2^GAIN_SHIFT means unity gain.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enableclk  in  1  DDS sample-rate strobe, one clock wide.
- audio_in  in  NBITS_AUDIO  signed audio sample.
- audio_valid  in  1  audio_in is valid.
- audio_ready  out  1  holding register empty; a sample is accepted this cycle.
- carrier_inc  in  NBITS_PHASE  centre-frequency phase increment, quasi-static.
- dev_gain  in  NBITS_GAIN  deviation gain, quasi-static.
- phaseinc  out  NBITS_PHASE  instantaneous phase increment to the DDS.
- underrun  out  1  sticky flag: a sample boundary found the holding register empty.
- clear_status  in  1  synchronous clear of underrun.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; phaseinc=0, audio_ready=1, underrun=0; holding register empty; tgt=0, acc=0, diff=0, cnt=0, pipeline registers 0.
- Handshake: a transfer occurs when audio_valid&&audio_ready. The sample is captured into the holding register and audio_ready drops on the next cycle. audio_ready returns to 1 on the cycle after the holding register is consumed. There is no combinational path from audio_valid to audio_ready.
- acc is signed, NBITS_AUDIO+INTERP_LOG2+1 bits, and represents the interpolated value × 2^INTERP_LOG2. interp = acc >>> INTERP_LOG2.
- IDLE: acc is held at 0. On the first enableclk tick with the holding register full, perform a "load" and go to RUN.
- Load on an enableclk tick:
  - diff <= hold − tgt (NBITS_AUDIO+1 bits, signed).
  - tgt <= hold.
  - acc <= tgt << INTERP_LOG2, snapping acc to the exact old target so no drift can accumulate.
  - cnt <= 0; holding register is consumed.
- RUN, enableclk tick with cnt != 2^INTERP_LOG2−1: acc <= acc + diff; cnt <= cnt+1.
  - After 2^INTERP_LOG2 ticks acc equals tgt×2^INTERP_LOG2 exactly.
- RUN, enableclk tick with cnt == 2^INTERP_LOG2−1 (boundary):
  - Holding register full: perform a load.
  - Holding register empty: diff <= 0, acc <= tgt<<INTERP_LOG2, cnt <= 0, underrun <= 1. The output holds flat at the last sample.
- Ticks without enableclk leave acc, cnt and state unchanged.
- Pipeline, running every clock:
  - S1: prod <= interp × dev_gain (signed × unsigned, full width).
  - S2: phaseinc <= carrier_inc + sign-extended (prod >>> GAIN_SHIFT), truncated modulo 2^NBITS_PHASE (wrap, no saturation).
  - Latency from an acc update to phaseinc: 2 clocks.
  - The enableclk period must be ≥3 clocks so phaseinc is settled before the DDS samples it.
- Simultaneous events:
  - Handshake accept and load in the same cycle: the load uses the previously held sample; the new sample fills the register.
  - clear_status and an underrun event in the same cycle: set wins.
- Reset mid-operation returns the block to IDLE; in-flight samples are discarded.

Decomposition:
- Shared package/include: NBITS_AUDIO, NBITS_PHASE, NBITS_GAIN, GAIN_SHIFT, and the IDLE/RUN state encoding, so the DDS and this block agree on widths.
- One sub-module, fm_interp_core, is natural: the acc/diff/cnt/tgt interpolator with load/boundary logic.
- The top level keeps the holding register, handshake, gain pipeline and status flag.

Test Plan:
- All tests use INTERP_LOG2=2, GAIN_SHIFT=15, dev_gain=0x8000, carrier_inc=0x10000000, enableclk every 4 clocks.
- Reset sequence: hold reset=0, then release → phaseinc=0 during reset; 2 clocks after release phaseinc=0x10000000; audio_ready=1.
- Ramp: samples 0 then 400 supplied in time → phaseinc steps carrier+100, +200, +300, +400 on successive ticks, then holds 0x10000190 if no more data.
- Negative and gain: dev_gain=0x4000, samples 0 → −400 → phaseinc reaches 0x10000000−200 = 0x0FFFFF38.
- Underrun: stop audio_valid after sample 400 → at the next boundary underrun=1 and phaseinc holds carrier+400; clear_status=1 → underrun=0.
- Backpressure: audio_valid held high continuously → exactly one accept per 4 enableclk ticks after the first fill; no sample dropped or duplicated (scoreboard vs. reference model).
- Wrap: carrier_inc=0xFFFFFF00, sample 512 → phaseinc wraps to 0x00000100 with no saturation.
